// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: divides MCLK into BCLK/LRCK and shifts out one captured
// DATA_WIDTH-bit sample per channel per frame, MSB first, with the I2S one-bit delay.
module i2s_tx_serializer #(
    parameter int MCLK_PER_BCLK = 8,
    parameter int SLOT_BITS     = 32,
    parameter int DATA_WIDTH    = 24
) (
    input  logic                         MCLK,
    input  logic                         RESET_N,
    input  logic                         MUTE,
    input  logic signed [DATA_WIDTH-1:0] LEFT_TX,
    input  logic signed [DATA_WIDTH-1:0] RIGHT_TX,
    output logic                         BCLK,
    output logic                         LRCK,
    output logic                         SDOUT,
    output logic                         TX_LOAD
);

    localparam int PW = (MCLK_PER_BCLK > 2) ? $clog2(MCLK_PER_BCLK) : 1;
    localparam int BW = $clog2(2 * SLOT_BITS);

    localparam logic [PW-1:0] P_LAST = PW'(MCLK_PER_BCLK - 1);
    localparam logic [PW-1:0] P_HALF = PW'(MCLK_PER_BCLK / 2);
    localparam logic [BW-1:0] B_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] B_SLOT = BW'(SLOT_BITS);

    // The frame counter is kept split as (bit-in-frame, mclk-in-bit) so no divider is needed.
    logic [PW-1:0]         p_q, p_d;
    logic [BW-1:0]         b_q, b_d;
    logic [DATA_WIDTH-1:0] l_hold_q, l_hold_d;
    logic [DATA_WIDTH-1:0] r_hold_q, r_hold_d;
    logic                  bclk_q, bclk_d;
    logic                  lrck_q, lrck_d;
    logic                  sdout_q, sdout_d;
    logic                  tx_load_q, tx_load_d;

    logic                  frame_start;
    logic                  right_slot;
    logic [BW-1:0]         k;
    logic [DATA_WIDTH-1:0] active;
    logic                  sel_bit;

    always_comb begin
        frame_start = (p_q == '0) && (b_q == '0);
        right_slot  = (b_q >= B_SLOT);
        k           = right_slot ? (b_q - B_SLOT) : b_q;
        active      = right_slot ? r_hold_q : l_hold_q;

        // Slot bit k carries sample bit DATA_WIDTH-k; k==0 and k>DATA_WIDTH stay 0.
        sel_bit = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (k == BW'(DATA_WIDTH - i)) begin
                sel_bit = active[i];
            end
        end

        p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
        b_d = b_q;
        if (p_q == P_LAST) begin
            b_d = (b_q == B_LAST) ? '0 : b_q + 1'b1;
        end

        bclk_d    = (p_q >= P_HALF);
        lrck_d    = right_slot;
        sdout_d   = (p_q == '0) ? sel_bit : sdout_q;
        tx_load_d = frame_start;

        l_hold_d = l_hold_q;
        r_hold_d = r_hold_q;
        if (frame_start) begin
            l_hold_d = MUTE ? '0 : LEFT_TX;
            r_hold_d = MUTE ? '0 : RIGHT_TX;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            p_q       <= '0;
            b_q       <= '0;
            l_hold_q  <= '0;
            r_hold_q  <= '0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
            sdout_q   <= 1'b0;
            tx_load_q <= 1'b0;
        end else begin
            p_q       <= p_d;
            b_q       <= b_d;
            l_hold_q  <= l_hold_d;
            r_hold_q  <= r_hold_d;
            bclk_q    <= bclk_d;
            lrck_q    <= lrck_d;
            sdout_q   <= sdout_d;
            tx_load_q <= tx_load_d;
        end
    end

    assign BCLK    = bclk_q;
    assign LRCK    = lrck_q;
    assign SDOUT   = sdout_q;
    assign TX_LOAD = tx_load_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: checks clock timing per MCLK cycle and
// decodes SDOUT on BCLK rise into left/right slots against hand-computed samples.
`timescale 1ns/1ps
module tb_i2s_tx_serializer;

    logic        MCLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        MUTE = 1'b0;
    logic [23:0] LEFT_TX = '0;
    logic [23:0] RIGHT_TX = '0;
    logic        BCLK, LRCK, SDOUT, TX_LOAD;

    int checks = 0;
    int failures = 0;

    int clk_err = 0;
    int load_err = 0;
    int sd_err = 0;
    int loads = 0;
    logic [31:0] lslot, rslot;

    i2s_tx_serializer #(
        .MCLK_PER_BCLK(8),
        .SLOT_BITS(32),
        .DATA_WIDTH(24)
    ) dut (
        .MCLK(MCLK),
        .RESET_N(RESET_N),
        .MUTE(MUTE),
        .LEFT_TX(LEFT_TX),
        .RIGHT_TX(RIGHT_TX),
        .BCLK(BCLK),
        .LRCK(LRCK),
        .SDOUT(SDOUT),
        .TX_LOAD(TX_LOAD)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs cnt 0..511 (or up to stop_at), sampling 1ns after each MCLK rise.
    task automatic run_frame(input int mid, input logic [23:0] mid_l, input logic [23:0] mid_r,
                             input logic mid_mute, input int stop_at);
        logic prev_sd;
        prev_sd = SDOUT;
        lslot = '0;
        rslot = '0;
        for (int c = 0; c < 512; c++) begin
            @(posedge MCLK);
            #1;
            if (BCLK !== ((c % 8) >= 4) || LRCK !== (c >= 256)) clk_err++;
            if (TX_LOAD !== (c == 0)) load_err++;
            if (TX_LOAD === 1'b1) loads++;
            if ((c % 8) != 0 && SDOUT !== prev_sd) sd_err++;
            prev_sd = SDOUT;
            if ((c % 8) == 4) begin
                if (c < 256) lslot[31 - (c / 8)] = SDOUT;
                else         rslot[31 - ((c / 8) - 32)] = SDOUT;
            end
            if (c == mid) begin
                LEFT_TX  = mid_l;
                RIGHT_TX = mid_r;
                MUTE     = mid_mute;
            end
            if (c == stop_at) break;
        end
    endtask

    task automatic check_frame(input string tag, input logic [23:0] el, input logic [23:0] er);
        check({tag, "_left"}, lslot[30:7], el);
        check({tag, "_right"}, rslot[30:7], er);
        check({tag, "_pad"}, {lslot[31], lslot[6:0], rslot[31], rslot[6:0]}, 32'h0);
    endtask

    initial begin
        #2;
        RESET_N  = 1'b0;
        LEFT_TX  = 24'h800001;
        RIGHT_TX = 24'h7FFFFE;
        #1;
        check("rst_outputs", {BCLK, LRCK, SDOUT, TX_LOAD}, 4'b0000);
        repeat (3) @(posedge MCLK);
        @(negedge MCLK);
        RESET_N = 1'b1;

        for (int f = 0; f < 4; f++) begin
            run_frame(-1, '0, '0, 1'b0, -1);
            check_frame("fmt", 24'h800001, 24'h7FFFFE);
        end
        check("tx_load_count", loads, 4);
        check("clk_timing", clk_err, 0);
        check("tx_load_timing", load_err, 0);
        check("sdout_stable", sd_err, 0);

        LEFT_TX  = 24'hFFFFFF;
        RIGHT_TX = 24'h800000;
        run_frame(-1, '0, '0, 1'b0, -1);
        check_frame("bound", 24'hFFFFFF, 24'h800000);

        LEFT_TX  = 24'h000000;
        RIGHT_TX = 24'h000000;
        run_frame(100, 24'h123456, 24'h000000, 1'b0, -1);
        check_frame("torn_cur", 24'h000000, 24'h000000);
        run_frame(-1, '0, '0, 1'b0, -1);
        check_frame("torn_next", 24'h123456, 24'h000000);

        MUTE     = 1'b1;
        LEFT_TX  = 24'h7FFFFF;
        RIGHT_TX = 24'h7FFFFF;
        run_frame(100, 24'h7FFFFF, 24'h7FFFFF, 1'b0, -1);
        check_frame("mute_cur", 24'h000000, 24'h000000);
        run_frame(-1, '0, '0, 1'b0, -1);
        check_frame("mute_next", 24'h7FFFFF, 24'h7FFFFF);

        LEFT_TX  = 24'h0F0F0F;
        RIGHT_TX = 24'hA5A5A5;
        run_frame(-1, '0, '0, 1'b0, 300);
        check("pre_rst_bclk_lrck", {BCLK, LRCK}, 2'b11);
        #2;
        RESET_N = 1'b0;
        #1;
        check("midrst_bclk", BCLK, 1'b0);
        check("midrst_lrck", LRCK, 1'b0);
        check("midrst_sdout_load", {SDOUT, TX_LOAD}, 2'b00);
        LEFT_TX  = 24'h654321;
        RIGHT_TX = 24'h89ABCD;
        repeat (3) @(posedge MCLK);
        @(negedge MCLK);
        RESET_N = 1'b1;
        load_err = 0;
        loads = 0;
        run_frame(-1, '0, '0, 1'b0, -1);
        check("post_rst_load", loads, 1);
        check("post_rst_load_timing", load_err, 0);
        check_frame("post_rst", 24'h654321, 24'h89ABCD);

        check("clk_timing_all", clk_err, 0);
        check("sdout_stable_all", sd_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
